// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, optional two-entry skid
// buffer, synchronous flush, and NOP zeroing of the output payload.
module pipe_stage_reg #(
  parameter int WIDTH   = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             headValid;
  logic [WIDTH-1:0] headData;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign pop       = headValid & out_ready;
  assign out_valid = headValid;
  // An empty stage presents all zeros so downstream decodes a NOP.
  assign out_data  = headValid ? headData : '0;

  generate
    if (SKID_EN) begin : gSkid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } FillState;

      FillState         state;
      FillState         stateNext;
      logic [WIDTH-1:0] skidData;
      logic [WIDTH-1:0] headNext;
      logic [WIDTH-1:0] skidNext;
      logic             readyReg;

      always_comb begin
        stateNext = state;
        headNext  = headData;
        skidNext  = skidData;
        if (flush) begin
          stateNext = EMPTY;
          headNext  = '0;
          skidNext  = '0;
        end else begin
          case (state)
            EMPTY: begin
              if (push) begin
                stateNext = ONE;
                headNext  = in_data;
              end
            end
            ONE: begin
              if (push && !pop) begin
                stateNext = TWO;
                skidNext  = in_data;
              end else if (pop && !push) begin
                stateNext = EMPTY;
                headNext  = '0;
              end else if (push && pop) begin
                headNext  = in_data;
              end
            end
            TWO: begin
              // in_ready is low here, so only a pop can move the stage.
              if (pop) begin
                stateNext = ONE;
                headNext  = skidData;
                skidNext  = '0;
              end
            end
            default: begin
              stateNext = EMPTY;
              headNext  = '0;
              skidNext  = '0;
            end
          endcase
        end
      end

      // Ready is registered from the next fill level, so it is low exactly while full.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state    <= EMPTY;
          headData <= '0;
          skidData <= '0;
          readyReg <= 1'b1;
        end else begin
          state    <= stateNext;
          headData <= headNext;
          skidData <= skidNext;
          readyReg <= (stateNext != TWO);
        end
      end

      assign headValid = (state != EMPTY);
      assign in_ready  = readyReg;
      assign occupancy = state;
    end else begin : gSingle
      logic validReg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          validReg <= 1'b0;
          headData <= '0;
        end else if (flush) begin
          validReg <= 1'b0;
          headData <= '0;
        end else if (push) begin
          validReg <= 1'b1;
          headData <= in_data;
        end else if (pop) begin
          validReg <= 1'b0;
          headData <= '0;
        end
      end

      assign headValid = validReg;
      assign in_ready  = !validReg | out_ready;
      assign occupancy = {1'b0, validReg};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one single-entry and one skid instance, table vectors,
// hand sequences for stall/reset corners, and random traffic against a queue model.
module tb_pipe_stage_reg;
  localparam int W = 64;

  typedef struct {
    logic         flush;
    logic         inValid;
    logic [W-1:0] inData;
    logic         outReady;
    logic         expValid;
    logic [W-1:0] expData;
    logic [1:0]   expOcc;
    logic         expRdy;
  } Vector;

  logic         CLK = 1'b0;
  logic         RST;
  logic         flushS   [2];
  logic         inValid  [2];
  logic [W-1:0] inData   [2];
  logic         outReady [2];
  logic [1:0]   inReady;
  logic [1:0]   outValid;
  logic [W-1:0] outData  [2];
  logic [1:0]   occ      [2];

  int errors = 0;
  int checks = 0;

  // Reference model: each stage is just a FIFO of bounded depth.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  Vector skidVecs[$];
  Vector singleVecs[$];

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b0)) dutSingle (
    .CLK(CLK), .RST(RST), .flush(flushS[0]),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b1)) dutSkid (
    .CLK(CLK), .RST(RST), .flush(flushS[1]),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .occupancy(occ[1])
  );

  function automatic Vector vec(input logic f, input logic v, input logic [W-1:0] d,
                                input logic r, input logic eV, input logic [W-1:0] eD,
                                input logic [1:0] eO, input logic eR);
    Vector x;
    x.flush = f; x.inValid = v; x.inData = d; x.outReady = r;
    x.expValid = eV; x.expData = eD; x.expOcc = eO; x.expRdy = eR;
    return x;
  endfunction

  task automatic applyStimulus(input int m, input logic f, input logic v,
                               input logic [W-1:0] d, input logic r);
    flushS[m]   = f;
    inValid[m]  = v;
    inData[m]   = d;
    outReady[m] = r;
  endtask

  task automatic checkOutput(input int m, input string tag, input logic eV,
                             input logic [W-1:0] eD, input logic [1:0] eO, input logic eR);
    checks += 4;
    if (outValid[m] !== eV) begin
      errors++;
      $display("[TB] FAIL %s (skid=%0d) out_valid got %b want %b", tag, m, outValid[m], eV);
    end
    if (outData[m] !== eD) begin
      errors++;
      $display("[TB] FAIL %s (skid=%0d) out_data got %h want %h", tag, m, outData[m], eD);
    end
    if (occ[m] !== eO) begin
      errors++;
      $display("[TB] FAIL %s (skid=%0d) occupancy got %0d want %0d", tag, m, occ[m], eO);
    end
    if (inReady[m] !== eR) begin
      errors++;
      $display("[TB] FAIL %s (skid=%0d) in_ready got %b want %b", tag, m, inReady[m], eR);
    end
  endtask

  function automatic int modelSize(input int m);
    return (m == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic modelReady(input int m);
    int sz = modelSize(m);
    if (m == 1) return (sz != 2);
    return (sz == 0) || outReady[0];
  endfunction

  task automatic modelCheck(input int m, input string tag);
    int sz = modelSize(m);
    logic [W-1:0] head = '0;
    if (sz > 0) head = (m == 1) ? q1[0] : q0[0];
    checkOutput(m, tag, sz != 0, head, 2'(sz), modelReady(m));
  endtask

  // Apply the transfer rules to the model using the inputs currently driven.
  task automatic modelStep(input int m);
    logic doPush = inValid[m] && modelReady(m);
    logic doPop  = (modelSize(m) > 0) && outReady[m];
    if (flushS[m]) begin
      if (m == 1) q1.delete(); else q0.delete();
    end else begin
      if (doPop) begin
        if (m == 1) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      if (doPush) begin
        if (m == 1) q1.push_back(inData[m]); else q0.push_back(inData[m]);
      end
    end
  endtask

  initial begin
    // Skid mode: first push, streaming, stall, flush.
    skidVecs.push_back(vec(0, 1, 64'hDEAD_BEEF_0000_0004, 1, 1, 64'hDEAD_BEEF_0000_0004, 1, 1));
    for (int k = 1; k <= 8; k++)
      skidVecs.push_back(vec(0, 1, 64'(k), 1, 1, 64'(k), 1, 1));
    skidVecs.push_back(vec(0, 0, 64'h0, 1, 0, 64'h0, 0, 1));
    skidVecs.push_back(vec(0, 1, 64'hA, 0, 1, 64'hA, 1, 1));
    skidVecs.push_back(vec(0, 1, 64'hB, 0, 1, 64'hA, 2, 0));
    skidVecs.push_back(vec(0, 1, 64'hC, 0, 1, 64'hA, 2, 0));
    skidVecs.push_back(vec(0, 1, 64'hC, 1, 1, 64'hB, 1, 1));
    skidVecs.push_back(vec(0, 1, 64'hC, 1, 1, 64'hC, 1, 1));
    skidVecs.push_back(vec(0, 0, 64'h0, 1, 0, 64'h0, 0, 1));
    skidVecs.push_back(vec(0, 1, 64'h11, 0, 1, 64'h11, 1, 1));
    skidVecs.push_back(vec(0, 1, 64'h12, 0, 1, 64'h11, 2, 0));
    skidVecs.push_back(vec(1, 1, 64'hF, 0, 0, 64'h0, 0, 1));
    skidVecs.push_back(vec(0, 0, 64'h0, 1, 0, 64'h0, 0, 1));
    skidVecs.push_back(vec(0, 1, 64'h21, 0, 1, 64'h21, 1, 1));
    skidVecs.push_back(vec(1, 1, 64'h22, 1, 0, 64'h0, 0, 1));
    skidVecs.push_back(vec(0, 0, 64'h0, 0, 0, 64'h0, 0, 1));

    // Single-entry mode: in_ready follows out_ready combinationally.
    singleVecs.push_back(vec(0, 1, 64'h5A, 0, 1, 64'h5A, 1, 0));
    singleVecs.push_back(vec(0, 1, 64'h77, 0, 1, 64'h5A, 1, 0));
    singleVecs.push_back(vec(0, 1, 64'h5, 1, 1, 64'h5, 1, 1));
    singleVecs.push_back(vec(0, 0, 64'h0, 1, 0, 64'h0, 0, 1));
    singleVecs.push_back(vec(0, 1, 64'h6, 1, 1, 64'h6, 1, 1));
    singleVecs.push_back(vec(0, 1, 64'h7, 1, 1, 64'h7, 1, 1));
    singleVecs.push_back(vec(1, 1, 64'h8, 1, 0, 64'h0, 0, 1));
    singleVecs.push_back(vec(0, 0, 64'h0, 0, 0, 64'h0, 0, 1));

    RST = 1'b1;
    for (int m = 0; m < 2; m++) applyStimulus(m, 0, 0, '0, 0);
    repeat (2) @(negedge CLK);
    #1;
    checkOutput(0, "reset", 0, '0, 0, 1);
    checkOutput(1, "reset", 0, '0, 0, 1);
    @(negedge CLK);
    RST = 1'b0;

    foreach (skidVecs[i]) begin
      applyStimulus(1, skidVecs[i].flush, skidVecs[i].inValid, skidVecs[i].inData, skidVecs[i].outReady);
      @(negedge CLK);
      checkOutput(1, $sformatf("skid vec %0d", i), skidVecs[i].expValid, skidVecs[i].expData,
                  skidVecs[i].expOcc, skidVecs[i].expRdy);
    end
    applyStimulus(1, 0, 0, '0, 0);

    foreach (singleVecs[i]) begin
      applyStimulus(0, singleVecs[i].flush, singleVecs[i].inValid, singleVecs[i].inData, singleVecs[i].outReady);
      @(negedge CLK);
      checkOutput(0, $sformatf("single vec %0d", i), singleVecs[i].expValid, singleVecs[i].expData,
                  singleVecs[i].expOcc, singleVecs[i].expRdy);
    end

    // Single-entry stall: in_ready tracks out_ready within the same cycle.
    applyStimulus(0, 0, 1, 64'h40, 1);
    @(negedge CLK);
    checkOutput(0, "single load", 1, 64'h40, 1, 1);
    applyStimulus(0, 0, 0, '0, 0);
    #1;
    checkOutput(0, "single stall same cycle", 1, 64'h40, 1, 0);
    applyStimulus(0, 0, 1, 64'h41, 1);
    #1;
    checkOutput(0, "single release same cycle", 1, 64'h40, 1, 1);
    @(negedge CLK);
    checkOutput(0, "single replace", 1, 64'h41, 1, 1);
    applyStimulus(0, 0, 0, '0, 1);
    @(negedge CLK);
    checkOutput(0, "single drain", 0, '0, 0, 1);

    // Asynchronous reset while the skid stage is full.
    applyStimulus(1, 0, 1, 64'h31, 0);
    applyStimulus(0, 0, 1, 64'h50, 0);
    @(negedge CLK);
    checkOutput(1, "prefill one", 1, 64'h31, 1, 1);
    applyStimulus(1, 0, 1, 64'h32, 0);
    @(negedge CLK);
    checkOutput(1, "prefill two", 1, 64'h31, 2, 0);
    checkOutput(0, "prefill single", 1, 64'h50, 1, 0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput(1, "async reset", 0, '0, 0, 1);
    checkOutput(0, "async reset", 0, '0, 0, 1);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1, 0, 1, 64'h9, 1);
    applyStimulus(0, 0, 0, '0, 0);
    @(negedge CLK);
    checkOutput(1, "push after reset", 1, 64'h9, 1, 1);
    applyStimulus(1, 0, 0, '0, 1);
    @(negedge CLK);
    checkOutput(1, "drain after reset", 0, '0, 0, 1);

    // Random traffic on both instances against the FIFO model.
    RST = 1'b1;
    for (int m = 0; m < 2; m++) applyStimulus(m, 0, 0, '0, 0);
    q0.delete();
    q1.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      for (int m = 0; m < 2; m++)
        applyStimulus(m, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                      {$urandom, $urandom}, $urandom_range(0, 9) < 6);
      #1;
      for (int m = 0; m < 2; m++) begin
        modelCheck(m, $sformatf("random cycle %0d", c));
        modelStep(m);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
